// File: rtl/sig_gen_pkg.sv
// sig_gen_pkg: shared mode encoding and defaults for the signal generator
package sig_gen_pkg;

    localparam int CNT_W_DEF = 32;

    typedef enum logic [1:0] {
        MODE_OFF     = 2'b00,
        MODE_CONT    = 2'b01,
        MODE_ONESHOT = 2'b10,
        MODE_RSVD    = 2'b11
    } mode_e;

    // Reserved encoding is treated as off, so only these two ever generate
    function automatic logic mode_runs(input mode_e m);
        return (m == MODE_CONT) || (m == MODE_ONESHOT);
    endfunction

endpackage

// File: rtl/sig_gen_channel.sv
// sig_gen_channel: one waveform channel with shadow/active config, counter and registered outputs
module sig_gen_channel
    import sig_gen_pkg::*;
#(
    parameter int          CNT_W      = CNT_W_DEF,
    parameter int unsigned DEF_PERIOD = 50000,
    parameter int unsigned DEF_HIGH   = 25000
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_we,
    input  logic [1:0]       i_mode,
    input  logic [CNT_W-1:0] i_period,
    input  logic [CNT_W-1:0] i_high,
    input  logic             i_trig,
    output logic             o_pending,
    output logic             o_signal,
    output logic             o_tick,
    output logic             o_busy
);

    mode_e            r_mode;
    mode_e            r_s_mode;
    logic [CNT_W-1:0] r_period;
    logic [CNT_W-1:0] r_high;
    logic [CNT_W-1:0] r_s_period;
    logic [CNT_W-1:0] r_s_high;
    logic [CNT_W-1:0] r_cnt;
    logic             r_pend;
    logic             r_busy;
    logic             r_signal;
    logic             r_tick;

    logic             w_acc;
    logic             w_wrap;
    logic             w_apply;
    logic             w_start;
    mode_e            w_mode;
    logic [CNT_W-1:0] w_period;

    // A write is only taken while nothing is pending, so accept and apply never coincide
    assign w_acc    = i_we & ~r_pend;
    assign w_wrap   = r_busy && (r_cnt == r_period - CNT_W'(1));
    assign w_apply  = r_pend && (!r_busy || w_wrap);
    assign w_mode   = w_apply ? r_s_mode : r_mode;
    assign w_period = w_apply ? r_s_period : r_period;
    // Start decision uses the config that will be active next cycle, so a new mode takes effect on the boundary itself
    assign w_start  = mode_runs(w_mode) && (w_period != '0) && ((w_mode == MODE_CONT) || i_trig);

    // Shadow capture on accept, shadow-to-active transfer only at period boundaries or when idle
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_mode     <= MODE_OFF;
            r_period   <= CNT_W'(DEF_PERIOD);
            r_high     <= CNT_W'(DEF_HIGH);
            r_s_mode   <= MODE_OFF;
            r_s_period <= CNT_W'(DEF_PERIOD);
            r_s_high   <= CNT_W'(DEF_HIGH);
            r_pend     <= 1'b0;
        end else begin
            if (w_acc) begin
                r_s_mode   <= mode_e'(i_mode);
                r_s_period <= i_period;
                r_s_high   <= i_high;
            end
            if (w_apply) begin
                r_mode   <= r_s_mode;
                r_period <= r_s_period;
                r_high   <= r_s_high;
            end
            r_pend <= w_acc | (r_pend & ~w_apply);
        end
    end

    // Counter runs within a period; at a wrap or while idle it restarts from 0 if the channel should run
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt    <= '0;
            r_busy   <= 1'b0;
            r_signal <= 1'b0;
            r_tick   <= 1'b0;
        end else begin
            if (r_busy && !w_wrap) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end else begin
                r_cnt  <= '0;
                r_busy <= w_start;
            end
            r_signal <= r_busy && (r_cnt < r_high);
            r_tick   <= w_wrap;
        end
    end

    assign o_pending = r_pend;
    assign o_signal  = r_signal;
    assign o_tick    = r_tick;
    assign o_busy    = r_busy;

endmodule

// File: rtl/multi_channel_signal_generator.sv
// multi_channel_signal_generator: NUM_CH programmable PWM/one-shot channels behind one config port
module multi_channel_signal_generator
    import sig_gen_pkg::*;
#(
    parameter int          NUM_CH     = 4,
    parameter int          CNT_W      = CNT_W_DEF,
    parameter int unsigned DEF_PERIOD = 50000,
    parameter int unsigned DEF_HIGH   = 25000,
    parameter int          CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_cfg_valid,
    output logic              o_cfg_ready,
    input  logic [CH_W-1:0]   i_cfg_ch,
    input  logic [1:0]        i_cfg_mode,
    input  logic [CNT_W-1:0]  i_cfg_period,
    input  logic [CNT_W-1:0]  i_cfg_high,
    input  logic [NUM_CH-1:0] i_trig,
    output logic [NUM_CH-1:0] o_signal,
    output logic [NUM_CH-1:0] o_period_tick,
    output logic [NUM_CH-1:0] o_busy
);

    logic [NUM_CH-1:0] w_pend;
    logic [NUM_CH-1:0] w_we;

    // Ready follows the addressed channel's pending flag; out-of-range channels are always ready and swallowed
    always_comb begin
        o_cfg_ready = 1'b1;
        for (int i = 0; i < NUM_CH; i++)
            if (i_cfg_ch == CH_W'(i)) o_cfg_ready = ~w_pend[i];
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        assign w_we[g] = i_cfg_valid && (i_cfg_ch == CH_W'(g));
        sig_gen_channel #(
            .CNT_W      (CNT_W),
            .DEF_PERIOD (DEF_PERIOD),
            .DEF_HIGH   (DEF_HIGH)
        ) u_ch (
            .i_clk     (i_clk),
            .i_rst_n   (i_rst_n),
            .i_we      (w_we[g]),
            .i_mode    (i_cfg_mode),
            .i_period  (i_cfg_period),
            .i_high    (i_cfg_high),
            .i_trig    (i_trig[g]),
            .o_pending (w_pend[g]),
            .o_signal  (o_signal[g]),
            .o_tick    (o_period_tick[g]),
            .o_busy    (o_busy[g])
        );
    end

endmodule

// File: tb/tb_multi_channel_signal_generator.sv
// tb_multi_channel_signal_generator: directed self-checking bench for the signal generator
module tb_multi_channel_signal_generator;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cfg_valid = 1'b0;
    logic        cfg_ready;
    logic [2:0]  cfg_ch = '0;
    logic [1:0]  cfg_mode = '0;
    logic [31:0] cfg_period = '0;
    logic [31:0] cfg_high = '0;
    logic [3:0]  trig = '0;
    logic [3:0]  sig;
    logic [3:0]  tick;
    logic [3:0]  busy;
    int total = 0;
    int bad = 0;

    multi_channel_signal_generator #(
        .NUM_CH     (4),
        .CNT_W      (32),
        .DEF_PERIOD (50000),
        .DEF_HIGH   (25000),
        .CH_W       (3)
    ) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_cfg_valid   (cfg_valid),
        .o_cfg_ready   (cfg_ready),
        .i_cfg_ch      (cfg_ch),
        .i_cfg_mode    (cfg_mode),
        .i_cfg_period  (cfg_period),
        .i_cfg_high    (cfg_high),
        .i_trig        (trig),
        .o_signal      (sig),
        .o_period_tick (tick),
        .o_busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        cfg_valid = 1'b0;
        trig = '0;
        cyc(2);
        rst_n = 1'b1;
    endtask

    // Returns one step after the accepting edge; gives up after a bounded number of cycles
    task automatic cfg(input logic [2:0] ch, input logic [1:0] mode, input logic [31:0] period, input logic [31:0] high);
        logic acc;
        acc = 1'b0;
        cfg_valid = 1'b1;
        cfg_ch = ch;
        cfg_mode = mode;
        cfg_period = period;
        cfg_high = high;
        #1;
        for (int k = 0; k < 40 && !acc; k++) begin
            acc = cfg_ready;
            cyc(1);
        end
        cfg_valid = 1'b0;
        check("cfg_accept", {31'd0, acc}, 32'd1);
    endtask

    initial begin
        int n;
        int p[4];
        logic [3:0] e;
        p = '{3, 5, 7, 11};

        // Reset values
        do_reset;
        check("rst_sig", {28'd0, sig}, 32'd0);
        check("rst_busy", {28'd0, busy}, 32'd0);
        check("rst_tick", {28'd0, tick}, 32'd0);
        check("rst_ready", {31'd0, cfg_ready}, 32'd1);

        // 1) continuous period 4 high 1 -> 1000 repeating
        cfg(3'd0, 2'b01, 32'd4, 32'd1);
        cyc(1);
        check("t1_busy", {31'd0, busy[0]}, 32'd1);
        check("t1_sig0", {31'd0, sig[0]}, 32'd0);
        for (int k = 0; k < 12; k++) begin
            cyc(1);
            check("t1_sig", {31'd0, sig[0]}, {31'd0, (k % 4) == 0});
            check("t1_tick", {31'd0, tick[0]}, {31'd0, (k % 4) == 3});
        end

        // 2) reconfigure mid-period; second write held off until the first applies
        do_reset;
        cfg(3'd0, 2'b01, 32'd10, 32'd5);
        cyc(3);
        cfg_valid = 1'b1;
        cfg_ch = 3'd0;
        cfg_mode = 2'b01;
        cfg_period = 32'd6;
        cfg_high = 32'd3;
        cyc(1);
        check("t2_stall", {31'd0, cfg_ready}, 32'd0);
        cfg_high = 32'd2;
        cyc(6);
        check("t2_stall_late", {31'd0, cfg_ready}, 32'd0);
        check("t2_old_low", {31'd0, sig[0]}, 32'd0);
        cyc(1);
        check("t2_old_tick", {31'd0, tick[0]}, 32'd1);
        check("t2_ready_back", {31'd0, cfg_ready}, 32'd1);
        cyc(1);
        cfg_valid = 1'b0;
        check("t2_second_taken", {31'd0, cfg_ready}, 32'd0);
        for (int k = 0; k < 12; k++) begin
            check("t2_sig", {31'd0, sig[0]}, {31'd0, (k < 6) ? (k < 3) : ((k - 6) < 2)});
            check("t2_tick", {31'd0, tick[0]}, {31'd0, (k == 5) || (k == 11)});
            cyc(1);
        end

        // 3) one-shot: single pulse, trig while busy ignored, held trig repeats with no gap
        do_reset;
        cfg(3'd1, 2'b10, 32'd8, 32'd3);
        cyc(1);
        check("t3_idle", {31'd0, busy[1]}, 32'd0);
        trig[1] = 1'b1;
        cyc(1);
        trig[1] = 1'b0;
        check("t3_start", {31'd0, busy[1]}, 32'd1);
        for (int k = 0; k < 8; k++) begin
            cyc(1);
            if (k == 1) trig[1] = 1'b1;
            if (k == 2) trig[1] = 1'b0;
            check("t3_sig", {31'd0, sig[1]}, {31'd0, k < 3});
            check("t3_tick", {31'd0, tick[1]}, {31'd0, k == 7});
            check("t3_busy", {31'd0, busy[1]}, {31'd0, k < 7});
        end
        cyc(1);
        check("t3_done_sig", {31'd0, sig[1]}, 32'd0);
        check("t3_done_busy", {31'd0, busy[1]}, 32'd0);
        check("t3_done_tick", {31'd0, tick[1]}, 32'd0);
        cyc(2);
        check("t3_stay_idle", {31'd0, busy[1]}, 32'd0);
        trig[1] = 1'b1;
        cyc(1);
        check("t3_rep_start", {31'd0, busy[1]}, 32'd1);
        for (int k = 1; k <= 16; k++) begin
            cyc(1);
            check("t3_rep_busy", {31'd0, busy[1]}, 32'd1);
            check("t3_rep_sig", {31'd0, sig[1]}, {31'd0, ((k - 1) % 8) < 3});
            check("t3_rep_tick", {31'd0, tick[1]}, {31'd0, (k % 8) == 0});
        end
        trig[1] = 1'b0;

        // 4a) period 0 behaves as off
        do_reset;
        cfg(3'd2, 2'b01, 32'd0, 32'd3);
        for (int k = 0; k < 8; k++) begin
            cyc(1);
            check("t4_p0", {29'd0, busy[2], sig[2], tick[2]}, 32'd0);
        end
        // 4b) high 0 -> signal low, ticks still every period
        do_reset;
        cfg(3'd2, 2'b01, 32'd5, 32'd0);
        cyc(1);
        n = 0;
        for (int k = 0; k < 10; k++) begin
            cyc(1);
            check("t4_h0_sig", {31'd0, sig[2]}, 32'd0);
            n += int'(tick[2]);
        end
        check("t4_h0_ticks", n, 32'd2);
        // 4c) high > period -> constant high with ticks
        do_reset;
        cfg(3'd2, 2'b01, 32'd5, 32'd7);
        cyc(1);
        n = 0;
        for (int k = 0; k < 10; k++) begin
            cyc(1);
            check("t4_hbig_sig", {31'd0, sig[2]}, 32'd1);
            n += int'(tick[2]);
        end
        check("t4_hbig_ticks", n, 32'd2);
        // 4d) period 1 -> high and tick every cycle
        do_reset;
        cfg(3'd2, 2'b01, 32'd1, 32'd1);
        cyc(1);
        for (int k = 0; k < 6; k++) begin
            cyc(1);
            check("t4_p1", {30'd0, sig[2], tick[2]}, 32'd3);
        end
        // 4e) reserved mode is off
        do_reset;
        cfg(3'd2, 2'b11, 32'd4, 32'd2);
        cyc(3);
        check("t4_rsvd", {30'd0, busy[2], sig[2]}, 32'd0);

        // 5) asynchronous reset mid-high on all channels
        do_reset;
        cfg(3'd0, 2'b01, 32'd10, 32'd5);
        cfg(3'd1, 2'b01, 32'd10, 32'd5);
        cfg(3'd2, 2'b01, 32'd10, 32'd5);
        cfg(3'd3, 2'b01, 32'd10, 32'd5);
        cyc(2);
        check("t5_all_high", {28'd0, sig}, 32'hF);
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_async_sig", {28'd0, sig}, 32'd0);
        check("t5_async_busy", {28'd0, busy}, 32'd0);
        check("t5_async_tick", {28'd0, tick}, 32'd0);
        cyc(2);
        rst_n = 1'b1;
        cyc(5);
        check("t5_off_busy", {28'd0, busy}, 32'd0);
        check("t5_off_sig", {28'd0, sig}, 32'd0);
        check("t5_ready", {31'd0, cfg_ready}, 32'd1);

        // 6) four independent periods plus an out-of-range write
        do_reset;
        cfg(3'd0, 2'b01, 32'd3, 32'd1);
        cfg(3'd1, 2'b01, 32'd5, 32'd1);
        cfg(3'd2, 2'b01, 32'd7, 32'd1);
        cfg(3'd3, 2'b01, 32'd11, 32'd1);
        cfg_valid = 1'b1;
        cfg_ch = 3'd5;
        cfg_mode = 2'b00;
        cfg_period = 32'd2;
        cfg_high = 32'd1;
        #1;
        check("t6_oob_ready", {31'd0, cfg_ready}, 32'd1);
        cyc(1);
        cfg_valid = 1'b0;
        check("t6_busy", {28'd0, busy}, 32'hF);
        for (int t = 5; t < 45; t++) begin
            for (int i = 0; i < 4; i++)
                e[i] = (t > 2 + i) && (((t - 2 - i) % p[i]) == 0);
            check("t6_ticks", {28'd0, tick}, {28'd0, e});
            cyc(1);
        end
        check("t6_still_busy", {28'd0, busy}, 32'hF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
